// File: rtl/ysyx_23060077_lsu_axi.sv
// Load/store unit: one request at a time, single-beat bus access with lane-aligned
// data and byte strobes, registered sign/zero-extended result or error to the WBU.
module ysyx_23060077_lsu_axi #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_src1,
    input  logic [DATA_WIDTH-1:0] req_imm,
    input  logic [DATA_WIDTH-1:0] req_src2,
    output logic                  r_valid_o,
    output logic [ADDR_WIDTH-1:0] r_addr_o,
    input  logic                  r_ready_i,
    input  logic [DATA_WIDTH-1:0] r_data_i,
    input  logic [1:0]            r_resp_i,
    output logic                  w_valid_o,
    output logic [ADDR_WIDTH-1:0] w_addr_o,
    output logic [DATA_WIDTH-1:0] w_data_o,
    output logic [STRB_WIDTH-1:0] w_strb_o,
    input  logic                  w_ready_i,
    input  logic [1:0]            w_resp_i,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_rd_wen,
    output logic [1:0]            resp_err,
    output logic                  busy
);

    localparam int OFF_W = $clog2(STRB_WIDTH);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_BUS      = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    // Stores only exist for the signed size codes; 64-bit sizes only on RV64.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic store);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b011:                 ok = (DATA_WIDTH == 64);
            3'b100, 3'b101:         ok = ~store;
            3'b110:                 ok = ~store && (DATA_WIDTH == 64);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
        logic m;
        case (size)
            2'd1:    m = a[0];
            2'd2:    m = |a[1:0];
            2'd3:    m = |a[2:0];
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [STRB_WIDTH-1:0] size_mask(input logic [1:0] size);
        logic [STRB_WIDTH-1:0] m;
        case (size)
            2'd0:    m = STRB_WIDTH'(8'h01);
            2'd1:    m = STRB_WIDTH'(8'h03);
            2'd2:    m = STRB_WIDTH'(8'h0F);
            2'd3:    m = STRB_WIDTH'(8'hFF);
            default: m = STRB_WIDTH'(8'h00);
        endcase
        return m;
    endfunction

    // Push the field to the top, then shift back down logically or arithmetically.
    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [DATA_WIDTH-1:0] lane,
        input logic [1:0]            size,
        input logic                  is_unsigned
    );
        logic [6:0]            bits;
        logic [6:0]            sh;
        logic [DATA_WIDTH-1:0] up;
        logic [DATA_WIDTH-1:0] ext;
        bits = 7'd8 << size;
        if (bits >= 7'(DATA_WIDTH)) begin
            sh = 7'd0;
        end else begin
            sh = 7'(DATA_WIDTH) - bits;
        end
        up = lane << sh;
        if (is_unsigned) begin
            ext = up >> sh;
        end else begin
            ext = $unsigned($signed(up) >>> sh);
        end
        return ext;
    endfunction

    state_t                state_r;
    logic [OFF_W-1:0]      off_r;
    logic [1:0]            size_r;
    logic                  unsigned_r;

    logic [DATA_WIDTH-1:0] sum_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [OFF_W-1:0]      offset_s;
    logic [1:0]            size_s;
    logic                  req_bad_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic [STRB_WIDTH-1:0] wstrb_s;
    logic [DATA_WIDTH-1:0] rd_lane_s;
    logic [DATA_WIDTH-1:0] rd_ext_s;

    assign sum_s     = req_src1 + req_imm;
    assign addr_s    = ADDR_WIDTH'(sum_s);
    assign offset_s  = addr_s[OFF_W-1:0];
    assign size_s    = req_funct3[1:0];
    assign req_bad_s = ~funct3_legal(req_funct3, req_store) | misaligned(size_s, addr_s[2:0]);
    assign wdata_s   = req_src2 << {offset_s, 3'b000};
    assign wstrb_s   = size_mask(size_s) << offset_s;
    assign rd_lane_s = r_data_i >> {off_r, 3'b000};
    assign rd_ext_s  = extend_load(rd_lane_s, size_r, unsigned_r);

    assign req_ready = (state_r == IDLE);
    assign busy      = (state_r != IDLE);

    // Request FSM; every bus and response output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            off_r       <= '0;
            size_r      <= 2'd0;
            unsigned_r  <= 1'b0;
            r_valid_o   <= 1'b0;
            r_addr_o    <= '0;
            w_valid_o   <= 1'b0;
            w_addr_o    <= '0;
            w_data_o    <= '0;
            w_strb_o    <= '0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_rd_wen <= 1'b0;
            resp_err    <= ERR_NONE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        off_r      <= offset_s;
                        size_r     <= size_s;
                        unsigned_r <= req_funct3[2];
                        if (req_bad_s) begin
                            state_r     <= RESP;
                            resp_valid  <= 1'b1;
                            resp_data   <= '0;
                            resp_rd_wen <= 1'b0;
                            resp_err    <= ERR_MISALIGN;
                        end else if (req_store) begin
                            state_r   <= WR;
                            w_valid_o <= 1'b1;
                            w_addr_o  <= addr_s;
                            w_data_o  <= wdata_s;
                            w_strb_o  <= wstrb_s;
                        end else begin
                            state_r   <= RD;
                            r_valid_o <= 1'b1;
                            r_addr_o  <= addr_s;
                        end
                    end
                end
                RD: begin
                    if (r_ready_i) begin
                        state_r    <= RESP;
                        r_valid_o  <= 1'b0;
                        resp_valid <= 1'b1;
                        if (r_resp_i != 2'b00) begin
                            resp_data   <= '0;
                            resp_rd_wen <= 1'b0;
                            resp_err    <= ERR_BUS;
                        end else begin
                            resp_data   <= rd_ext_s;
                            resp_rd_wen <= 1'b1;
                            resp_err    <= ERR_NONE;
                        end
                    end
                end
                WR: begin
                    if (w_ready_i) begin
                        state_r     <= RESP;
                        w_valid_o   <= 1'b0;
                        w_data_o    <= '0;
                        w_strb_o    <= '0;
                        resp_valid  <= 1'b1;
                        resp_data   <= '0;
                        resp_rd_wen <= 1'b0;
                        resp_err    <= (w_resp_i != 2'b00) ? ERR_BUS : ERR_NONE;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_r     <= IDLE;
                        resp_valid  <= 1'b0;
                        resp_data   <= '0;
                        resp_rd_wen <= 1'b0;
                        resp_err    <= ERR_NONE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    r_valid_o  <= 1'b0;
                    w_valid_o  <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_lsu_axi.sv
// Scoreboard bench: a 32-bit and a 64-bit LSU share stimulus; sel picks the active one.
module tb_ysyx_23060077_lsu_axi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_src1 = 64'd0;
    logic [63:0] req_imm = 64'd0;
    logic [63:0] req_src2 = 64'd0;
    logic        r_ready_i = 1'b0;
    logic [63:0] r_data_i = 64'd0;
    logic [1:0]  r_resp_i = 2'd0;
    logic        w_ready_i = 1'b0;
    logic [1:0]  w_resp_i = 2'd0;
    logic        resp_ready = 1'b0;

    logic        req_ready_a, r_valid_a, w_valid_a, resp_valid_a, resp_rd_wen_a, busy_a;
    logic [31:0] r_addr_a, w_addr_a, w_data_a, resp_data_a;
    logic [3:0]  w_strb_a;
    logic [1:0]  resp_err_a;
    logic        req_ready_b, r_valid_b, w_valid_b, resp_valid_b, resp_rd_wen_b, busy_b;
    logic [31:0] r_addr_b, w_addr_b;
    logic [63:0] w_data_b, resp_data_b;
    logic [7:0]  w_strb_b;
    logic [1:0]  resp_err_b;

    ysyx_23060077_lsu_axi #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u_lsu32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(req_ready_a), .req_store(req_store),
        .req_funct3(req_funct3), .req_src1(req_src1[31:0]), .req_imm(req_imm[31:0]),
        .req_src2(req_src2[31:0]),
        .r_valid_o(r_valid_a), .r_addr_o(r_addr_a), .r_ready_i(r_ready_i),
        .r_data_i(r_data_i[31:0]), .r_resp_i(r_resp_i),
        .w_valid_o(w_valid_a), .w_addr_o(w_addr_a), .w_data_o(w_data_a), .w_strb_o(w_strb_a),
        .w_ready_i(w_ready_i), .w_resp_i(w_resp_i),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready && !sel), .resp_data(resp_data_a),
        .resp_rd_wen(resp_rd_wen_a), .resp_err(resp_err_a), .busy(busy_a)
    );

    ysyx_23060077_lsu_axi #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u_lsu64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(req_ready_b), .req_store(req_store),
        .req_funct3(req_funct3), .req_src1(req_src1), .req_imm(req_imm), .req_src2(req_src2),
        .r_valid_o(r_valid_b), .r_addr_o(r_addr_b), .r_ready_i(r_ready_i),
        .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .w_valid_o(w_valid_b), .w_addr_o(w_addr_b), .w_data_o(w_data_b), .w_strb_o(w_strb_b),
        .w_ready_i(w_ready_i), .w_resp_i(w_resp_i),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready && sel), .resp_data(resp_data_b),
        .resp_rd_wen(resp_rd_wen_b), .resp_err(resp_err_b), .busy(busy_b)
    );

    logic        req_ready_m, r_valid_m, w_valid_m, resp_valid_m, resp_rd_wen_m, busy_m;
    logic [31:0] r_addr_m, w_addr_m;
    logic [63:0] w_data_m, resp_data_m;
    logic [7:0]  w_strb_m;
    logic [1:0]  resp_err_m;

    assign req_ready_m   = sel ? req_ready_b   : req_ready_a;
    assign r_valid_m     = sel ? r_valid_b     : r_valid_a;
    assign w_valid_m     = sel ? w_valid_b     : w_valid_a;
    assign resp_valid_m  = sel ? resp_valid_b  : resp_valid_a;
    assign resp_rd_wen_m = sel ? resp_rd_wen_b : resp_rd_wen_a;
    assign busy_m        = sel ? busy_b        : busy_a;
    assign r_addr_m      = sel ? r_addr_b      : r_addr_a;
    assign w_addr_m      = sel ? w_addr_b      : w_addr_a;
    assign w_data_m      = sel ? w_data_b      : {32'h0, w_data_a};
    assign resp_data_m   = sel ? resp_data_b   : {32'h0, resp_data_a};
    assign w_strb_m      = sel ? w_strb_b      : {4'h0, w_strb_a};
    assign resp_err_m    = sel ? resp_err_b    : resp_err_a;

    typedef struct {
        logic [63:0] data;
        logic        wen;
        logic [1:0]  err;
        int          cyc;
        int          hold;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   issued = 0;
    int   resp_seen = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard on each new resp_valid, then completes the handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid_m === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: resp_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("resp_data", resp_data_m, e.data);
                    chk("resp_rd_wen", {63'd0, resp_rd_wen_m}, {63'd0, e.wen});
                    chk("resp_err", {62'd0, resp_err_m}, {62'd0, e.err});
                    for (int h = 0; h < e.hold; h++) begin
                        @(negedge clk);
                        chk("hold_valid", {63'd0, resp_valid_m}, 64'd1);
                        chk("hold_data", resp_data_m, e.data);
                        chk("hold_err", {62'd0, resp_err_m}, {62'd0, e.err});
                        chk("hold_req_ready", {63'd0, req_ready_m}, 64'd0);
                    end
                end
                resp_ready = 1'b1;
                @(negedge clk);
                resp_ready = 1'b0;
                resp_seen++;
            end
        end
    end

    // One request: bus slave answers k cycles after the valid rises; expectation queued up front.
    task automatic xact(input logic w64, input logic st, input logic [2:0] f3,
                        input logic [63:0] s1, input logic [63:0] im, input logic [63:0] s2,
                        input logic [63:0] rd, input logic [1:0] bresp, input int k, input int hold,
                        input logic [31:0] eaddr, input logic [63:0] ewdata, input logic [7:0] estrb,
                        input logic [63:0] edata, input logic ewen, input logic [1:0] eerr);
        int acc;
        @(negedge clk);
        sel        = w64;
        req_store  = st;
        req_funct3 = f3;
        req_src1   = s1;
        req_imm    = im;
        req_src2   = s2;
        req_valid  = 1'b1;
        acc        = cyc + 1;
        sb.push_back('{edata, ewen, eerr, (eerr == 2'd1) ? acc : acc + k, hold});
        issued++;
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy", {63'd0, busy_m}, 64'd1);
        if (eerr == 2'd1) begin
            chk("no_bus_valid", {62'd0, r_valid_m, w_valid_m}, 64'd0);
        end else begin
            chk("bus_valid", {62'd0, r_valid_m, w_valid_m}, st ? 64'd1 : 64'd2);
            chk("bus_addr", {32'd0, st ? w_addr_m : r_addr_m}, {32'd0, eaddr});
            if (st) begin
                chk("w_data", w_data_m, ewdata);
                chk("w_strb", {56'd0, w_strb_m}, {56'd0, estrb});
            end
            repeat (k - 1) @(negedge clk);
            if (k > 1) begin
                chk("bus_valid_held", {62'd0, r_valid_m, w_valid_m}, st ? 64'd1 : 64'd2);
            end
            if (st) begin
                w_ready_i = 1'b1;
                w_resp_i  = bresp;
            end else begin
                r_ready_i = 1'b1;
                r_data_i  = rd;
                r_resp_i  = bresp;
            end
            @(negedge clk);
            r_ready_i = 1'b0;
            w_ready_i = 1'b0;
            r_resp_i  = 2'd0;
            w_resp_i  = 2'd0;
            r_data_i  = 64'hA5A5_A5A5_A5A5_A5A5;
            chk("bus_valid_drop", {62'd0, r_valid_m, w_valid_m}, 64'd0);
        end
        for (int i = 0; i < 40 && resp_seen < issued; i++) @(negedge clk);
        chk("resp_done", 64'(resp_seen), 64'(issued));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_req_ready", {63'd0, req_ready_m}, 64'd1);
            chk("rst_outputs", {58'd0, busy_m, r_valid_m, w_valid_m, resp_valid_m, resp_rd_wen_m, |resp_err_m}, 64'd0);
            chk("rst_strb_data", {48'd0, w_strb_m, 8'd0} | resp_data_m | w_data_m, 64'd0);
        end

        // 32-bit loads and stores
        xact(0, 0, 3'b000, 64'h8000_0001, 64'h2, 64'h0, 64'h80FF_1234, 2'd0, 3, 0, 32'h8000_0003, 64'h0, 8'h00, 64'hFFFF_FF80, 1, 2'd0);
        xact(0, 1, 3'b001, 64'h8000_0000, 64'h2, 64'hDEAD_BEEF, 64'h0, 2'd0, 1, 0, 32'h8000_0002, 64'hBEEF_0000, 8'h0C, 64'h0, 0, 2'd0);
        xact(0, 0, 3'b101, 64'h8000_0000, 64'h2, 64'h0, 64'h80FF_1234, 2'd0, 1, 0, 32'h8000_0002, 64'h0, 8'h00, 64'h0000_80FF, 1, 2'd0);
        xact(0, 0, 3'b001, 64'h8000_0000, 64'h2, 64'h0, 64'h80FF_1234, 2'd0, 2, 0, 32'h8000_0002, 64'h0, 8'h00, 64'hFFFF_80FF, 1, 2'd0);
        xact(0, 0, 3'b010, 64'h8000_0000, 64'h4, 64'h0, 64'h1234_5678, 2'd0, 2, 1, 32'h8000_0004, 64'h0, 8'h00, 64'h1234_5678, 1, 2'd0);
        xact(0, 1, 3'b000, 64'h8000_0005, 64'hFFFF_FFFF_FFFF_FFFC, 64'hA5, 64'h0, 2'd0, 1, 0, 32'h8000_0001, 64'h0000_A500, 8'h02, 64'h0, 0, 2'd0);
        // misaligned / illegal codes on the 32-bit unit
        xact(0, 0, 3'b010, 64'h8000_0000, 64'h2, 64'h0, 64'h0, 2'd0, 1, 0, 32'h0, 64'h0, 8'h00, 64'h0, 0, 2'd1);
        xact(0, 0, 3'b111, 64'h8000_0000, 64'h0, 64'h0, 64'h0, 2'd0, 1, 0, 32'h0, 64'h0, 8'h00, 64'h0, 0, 2'd1);
        xact(0, 0, 3'b011, 64'h8000_0000, 64'h0, 64'h0, 64'h0, 2'd0, 1, 0, 32'h0, 64'h0, 8'h00, 64'h0, 0, 2'd1);
        xact(0, 1, 3'b100, 64'h8000_0000, 64'h0, 64'h0, 64'h0, 2'd0, 1, 0, 32'h0, 64'h0, 8'h00, 64'h0, 0, 2'd1);
        // bus errors, the write one with a stalled WBU
        xact(0, 1, 3'b010, 64'h8000_0008, 64'h0, 64'h1122_3344, 64'h0, 2'd2, 2, 5, 32'h8000_0008, 64'h1122_3344, 8'h0F, 64'h0, 0, 2'd2);
        xact(0, 0, 3'b010, 64'h8000_000C, 64'h0, 64'h0, 64'hFFFF_FFFF, 2'd2, 1, 0, 32'h8000_000C, 64'h0, 8'h00, 64'h0, 0, 2'd2);

        // 64-bit unit
        xact(1, 0, 3'b011, 64'h8000_0000, 64'h8, 64'h0, 64'h1122_3344_5566_7788, 2'd0, 2, 0, 32'h8000_0008, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 1, 2'd0);
        xact(1, 0, 3'b110, 64'h8000_0000, 64'h4, 64'h0, 64'hFFFF_FFFF_0000_0000, 2'd0, 1, 0, 32'h8000_0004, 64'h0, 8'h00, 64'h0000_0000_FFFF_FFFF, 1, 2'd0);
        xact(1, 0, 3'b010, 64'h8000_0000, 64'h4, 64'h0, 64'hFFFF_FFFF_0000_0000, 2'd0, 1, 0, 32'h8000_0004, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2'd0);
        xact(1, 0, 3'b000, 64'h8000_0005, 64'h0, 64'h0, 64'h0000_9A00_0000_0000, 2'd0, 3, 0, 32'h8000_0005, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF9A, 1, 2'd0);
        xact(1, 1, 3'b011, 64'h8000_0010, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 2'd0, 1, 0, 32'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 0, 2'd0);
        xact(1, 1, 3'b010, 64'h8000_0014, 64'h0, 64'h0000_0000_CAFE_F00D, 64'h0, 2'd0, 2, 2, 32'h8000_0014, 64'hCAFE_F00D_0000_0000, 8'hF0, 64'h0, 0, 2'd0);
        xact(1, 0, 3'b001, 64'h8000_0001, 64'h0, 64'h0, 64'h0, 2'd0, 1, 0, 32'h0, 64'h0, 8'h00, 64'h0, 0, 2'd1);
        xact(1, 0, 3'b011, 64'h8000_0004, 64'h0, 64'h0, 64'h0, 2'd0, 1, 0, 32'h0, 64'h0, 8'h00, 64'h0, 0, 2'd1);

        // reset two cycles into a read wait, then a late read response
        @(negedge clk);
        sel        = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_src1   = 64'h8000_0020;
        req_imm    = 64'h0;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_r_valid", {63'd0, r_valid_m}, 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", {61'd0, r_valid_m, req_ready_m, busy_m}, 64'd2);
        r_ready_i = 1'b1;
        r_data_i  = 64'h0BAD_0BAD;
        @(negedge clk);
        r_ready_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_resp", {63'd0, resp_valid_m}, 64'd0);
        xact(0, 0, 3'b100, 64'h8000_0003, 64'h0, 64'h0, 64'h7F00_0000, 2'd0, 1, 0, 32'h8000_0003, 64'h0, 8'h00, 64'h0000_007F, 1, 2'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060077_lsu_axi.md
# ysyx_23060077_lsu_axi

Parametrised load/store unit between the EXU and the data-side bus arbiter of the ysyx_23060077 core. It accepts one memory request at a time over a valid/ready handshake and computes the effective address. It drives a single-beat read or write with byte-lane-correct data and strobes, and returns a registered, sign/zero-extended result or an error to the WBU over a second valid/ready handshake. It extends the single-width LSU with RV64 sizes, true per-byte strobes, misalignment detection and bus-error reporting.

## Interface
- DATA_WIDTH, 32: register/bus data width; legal values 32 or 64.
- ADDR_WIDTH, 32: bus address width.
- STRB_WIDTH, DATA_WIDTH/8: byte strobes; OFF_W = log2(STRB_WIDTH).
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  EXU request valid.
- req_ready  out  1  LSU can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V size/sign code.
- req_src1  in  DATA_WIDTH  base register.
- req_imm  in  DATA_WIDTH  offset.
- req_src2  in  DATA_WIDTH  store data (LSB-aligned).
- r_valid_o  out  1  read request.
- r_addr_o  out  ADDR_WIDTH  read byte address.
- r_ready_i  in  1  read done; r_data_i/r_resp_i valid this cycle.
- r_data_i  in  DATA_WIDTH  read beat (lane-aligned).
- r_resp_i  in  2  0 = OKAY; nonzero = error.
- w_valid_o  out  1  write request.
- w_addr_o  out  ADDR_WIDTH  write byte address.
- w_data_o  out  DATA_WIDTH  lane-shifted store data.
- w_strb_o  out  STRB_WIDTH  byte enables.
- w_ready_i  in  1  write done; w_resp_i valid this cycle.
- w_resp_i  in  2  write response.
- resp_valid  out  1  result available to WBU.
- resp_ready  in  1  WBU accepts result.
- resp_data  out  DATA_WIDTH  extended load data; 0 for stores/errors.
- resp_rd_wen  out  1  1 only for a successful load.
- resp_err  out  2  0 none, 1 misaligned, 2 bus error.
- busy  out  1  state != IDLE (stall to IFU/IDU).

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid, register addr = src1+imm (truncated to ADDR_WIDTH), size, sign, store flag, store data.
  - Misaligned → RESP with err=1. Misaligned means: half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0.
  - Otherwise → RD or WR.
- funct3 legal set: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu. When DATA_WIDTH=64, also 011 ld/sd and 110 lwu.
  - Any other code, including a store with funct3[2]=1, → RESP with err=1 and no bus access.
- RD: r_valid_o=1, r_addr_o=addr, held stable until r_ready_i.
  - On r_ready_i, capture lane = r_data_i >> (8*addr[OFF_W-1:0]), then extend per size/sign.
  - r_resp_i≠0 → err=2, data=0, rd_wen=0. Go to RESP.
- WR: w_valid_o=1. w_data_o = src2 << (8*offset). w_strb_o = ((1<<bytes)-1) << offset.
  - Outputs held stable until w_ready_i; then RESP, with err=2 if w_resp_i≠0.
- RESP: resp_valid=1, outputs stable; on resp_ready → IDLE.
- Bus address is the unaligned byte address; bus slaves use the strobes.

## Timing
- Reset: state=IDLE. All outputs 0 except req_ready=1 (busy, valids, strb, data, err, rd_wen all 0).
- Request accepted in cycle T. The bus valid rises at T+1.
- If ready arrives at cycle T+k (k≥1), resp_valid rises at T+k+1.
- Minimum load/store latency: 2 cycles accept→resp_valid. Misaligned/illegal: resp_valid at T+1.
- Ready on the same cycle valid first rises is legal. Ready while the matching valid is low is ignored.
- No new request is accepted in the cycle resp handshake completes; earliest next accept is the following cycle (req_ready combinational from state).
- rst mid-transaction aborts immediately to IDLE next edge and drops the bus valid. Any pending bus response after reset is ignored.
- Bus valids never drop before ready (no withdrawal).

## Test plan
- DATA_WIDTH=32, lb: src1=0x8000_0001, imm=2, r_data_i=0x80FF_1234, ready at T+3 → r_addr_o=0x8000_0003, resp_data=0xFFFF_FF80, rd_wen=1, resp_valid at T+4.
- sh: addr 0x8000_0002, src2=0xDEAD_BEEF → w_data_o=0xBEEF_0000, w_strb_o=0b1100, resp_data=0, rd_wen=0.
- DATA_WIDTH=64, ld at 0x...8 with r_data_i=0x1122_3344_5566_7788 → full value returned. Then lwu at offset 4 of 0xFFFF_FFFF_0000_0000 → 0x0000_0000_FFFF_FFFF.
- Misaligned lw at 0x8000_0002, then illegal funct3=111 → no r_valid_o/w_valid_o ever, resp_valid at T+1, resp_err=1, rd_wen=0.
- Bus error: sw with w_resp_i=2 → resp_err=2. resp_ready held low 5 cycles → resp_valid and data stable throughout, req_ready=0.
- rst asserted two cycles into RD wait → next cycle r_valid_o=0, req_ready=1, busy=0. A late r_ready_i produces no resp_valid.
